// File: rtl/xintf_reg_bank.sv
// XINTF register bank: synchronised DSP bus writes into NUM_CH command channels,
// optional shadow/commit staging, status counters and a tri-state read-back path.
module xintf_reg_bank #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 20,
  parameter int                NUM_CH      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 20'h0FC01,
  parameter int                SHADOW_MODE = 0
) (
  input  logic                     clk,
  input  logic                     global_rst,
  input  logic                     xcs_n,
  input  logic                     wen,
  input  logic                     ren,
  input  logic [ADDR_W-1:0]        xadd,
  inout  wire  [DATA_W-1:0]        xdata,
  output logic [NUM_CH*DATA_W-1:0] dsp2fpga,
  output logic [NUM_CH-1:0]        upd_pulse,
  output logic                     commit_pulse
);

  logic              cs_s1, cs_s2, cs_d;
  logic              wen_s1, wen_s2, wen_d;
  logic              ren_s1, ren_s2;
  logic [ADDR_W-1:0] addr_s1, addr_s2, addr_d;
  logic [DATA_W-1:0] data_s1, data_s2, data_d;
  logic              warm_s1, warm_s2, armed;

  logic [DATA_W-1:0] shadow  [NUM_CH];
  logic [DATA_W-1:0] out_reg [NUM_CH];
  logic [7:0]        acc_cnt, unm_cnt;
  logic [DATA_W-1:0] rdata, rd_mux;
  logic              oe;

  logic              wr_event, wr_in, wr_is_ch, wr_is_commit, wr_is_status;
  logic [ADDR_W-1:0] wr_off, rd_off;

  // armed only sets once a synchronised (post-reset) high level of wen has been
  // seen, so a strobe held low across reset release can never produce an event
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      wen_s1  <= 1'b1;
      wen_s2  <= 1'b1;
      wen_d   <= 1'b1;
      ren_s1  <= 1'b1;
      ren_s2  <= 1'b1;
      addr_s1 <= '0;
      addr_s2 <= '0;
      addr_d  <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
      data_d  <= '0;
      warm_s1 <= 1'b0;
      warm_s2 <= 1'b0;
      armed   <= 1'b0;
    end else begin
      cs_s1   <= xcs_n;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      wen_s1  <= wen;
      wen_s2  <= wen_s1;
      wen_d   <= wen_s2;
      ren_s1  <= ren;
      ren_s2  <= ren_s1;
      addr_s1 <= xadd;
      addr_s2 <= addr_s1;
      addr_d  <= addr_s2;
      data_s1 <= xdata;
      data_s2 <= data_s1;
      data_d  <= data_s2;
      warm_s1 <= 1'b1;
      warm_s2 <= warm_s1;
      if (warm_s2 && wen_s2) armed <= 1'b1;
    end
  end

  assign wr_event     = armed && wen_s2 && !wen_d && !cs_d;
  assign wr_off       = addr_d - BASE_ADDR;
  assign wr_in        = (addr_d >= BASE_ADDR);
  assign wr_is_ch     = wr_in && (wr_off < ADDR_W'(NUM_CH));
  assign wr_is_commit = wr_in && (wr_off == ADDR_W'(NUM_CH));
  assign wr_is_status = wr_in && (wr_off == ADDR_W'(NUM_CH + 1));

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i]  <= '0;
        out_reg[i] <= '0;
      end
      acc_cnt      <= '0;
      unm_cnt      <= '0;
      upd_pulse    <= '0;
      commit_pulse <= 1'b0;
    end else begin
      upd_pulse    <= '0;
      commit_pulse <= 1'b0;
      if (wr_event) begin
        if (wr_is_status) begin
          acc_cnt <= '0;
          unm_cnt <= '0;
        end else if (wr_is_ch || wr_is_commit) begin
          acc_cnt <= acc_cnt + 8'd1;
        end else if (unm_cnt != 8'hFF) begin
          unm_cnt <= unm_cnt + 8'd1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_is_ch && (wr_off == ADDR_W'(i))) begin
            shadow[i] <= data_d;
            if (SHADOW_MODE == 0) begin
              out_reg[i]   <= data_d;
              upd_pulse[i] <= 1'b1;
            end
          end
        end
        // channel writes and commits are separate bus cycles, so shadow[] here is settled
        if (wr_is_commit && data_d[0]) begin
          commit_pulse <= 1'b1;
          if (SHADOW_MODE != 0) begin
            for (int i = 0; i < NUM_CH; i++) out_reg[i] <= shadow[i];
            upd_pulse <= '1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign dsp2fpga[g*DATA_W +: DATA_W] = out_reg[g];
  end

  assign rd_off = addr_s2 - BASE_ADDR;

  always_comb begin
    rd_mux = '0;
    if (addr_s2 >= BASE_ADDR) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_off == ADDR_W'(i)) rd_mux = shadow[i];
      end
      if (rd_off == ADDR_W'(NUM_CH + 1)) rd_mux = DATA_W'({acc_cnt, unm_cnt});
    end
  end

  // a read overlapping a write strobe never drives the bus
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      rdata <= '0;
      oe    <= 1'b0;
    end else begin
      rdata <= rd_mux;
      oe    <= !cs_s2 && !ren_s2 && wen_s2;
    end
  end

  assign xdata = oe ? rdata : 'z;

endmodule

// File: tb/tb_xintf_reg_bank.sv
// Self-checking bench for xintf_reg_bank: one direct-mode and one shadow-mode
// instance driven by the same bus, checked against a behavioural model.
module tb_xintf_reg_bank;

  localparam int              DW   = 16;
  localparam int              AW   = 20;
  localparam int              NCH  = 8;
  localparam logic [AW-1:0]   BASE = 20'h0FC01;

  logic          clk = 1'b0;
  logic          global_rst = 1'b0;
  logic          xcs_n = 1'b1;
  logic          wen = 1'b1;
  logic          ren = 1'b1;
  logic [AW-1:0] xadd = '0;
  logic          tb_drv = 1'b0;
  logic [DW-1:0] tb_wdata = '0;
  wire  [DW-1:0] xdata0, xdata1;

  logic [NCH*DW-1:0] dsp0, dsp1;
  logic [NCH-1:0]    upd0, upd1;
  logic              com0, com1;

  assign xdata0 = tb_drv ? tb_wdata : 'z;
  assign xdata1 = tb_drv ? tb_wdata : 'z;

  xintf_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .BASE_ADDR(BASE), .SHADOW_MODE(0)) dut0 (
    .clk(clk), .global_rst(global_rst), .xcs_n(xcs_n), .wen(wen), .ren(ren), .xadd(xadd),
    .xdata(xdata0), .dsp2fpga(dsp0), .upd_pulse(upd0), .commit_pulse(com0));

  xintf_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .BASE_ADDR(BASE), .SHADOW_MODE(1)) dut1 (
    .clk(clk), .global_rst(global_rst), .xcs_n(xcs_n), .wen(wen), .ren(ren), .xadd(xadd),
    .xdata(xdata1), .dsp2fpga(dsp1), .upd_pulse(upd1), .commit_pulse(com1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model of the register map
  logic [DW-1:0]  m_shadow [NCH];
  logic [DW-1:0]  m_out0   [NCH];
  logic [DW-1:0]  m_out1   [NCH];
  int             m_acc, m_unm;
  logic [NCH-1:0] e_upd0, e_upd1;
  logic           e_com;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_shadow[i] = '0;
      m_out0[i]   = '0;
      m_out1[i]   = '0;
    end
    m_acc = 0;
    m_unm = 0;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int off;
    off    = int'(a) - int'(BASE);
    e_upd0 = '0;
    e_upd1 = '0;
    e_com  = 1'b0;
    if (off >= 0 && off < NCH) begin
      m_shadow[off] = d;
      m_out0[off]   = d;
      e_upd0[off]   = 1'b1;
      m_acc         = (m_acc + 1) % 256;
    end else if (off == NCH) begin
      m_acc = (m_acc + 1) % 256;
      if (d[0]) begin
        e_com = 1'b1;
        for (int i = 0; i < NCH; i++) m_out1[i] = m_shadow[i];
        e_upd1 = '1;
      end
    end else if (off == NCH + 1) begin
      m_acc = 0;
      m_unm = 0;
    end else if (m_unm < 255) begin
      m_unm = m_unm + 1;
    end
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    int off;
    off = int'(a) - int'(BASE);
    if (off >= 0 && off < NCH) return m_shadow[off];
    if (off == NCH + 1) return DW'(m_acc * 256 + m_unm);
    return '0;
  endfunction

  function automatic logic [NCH*DW-1:0] packed_out(input bit sel);
    logic [NCH*DW-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*DW +: DW] = sel ? m_out1[i] : m_out0[i];
    return v;
  endfunction

  // an undriven bus reads as z in 4-state simulators and as 0 in 2-state ones
  function automatic bit undriven(input logic [DW-1:0] x);
    return (x === 'z) || (x === '0);
  endfunction

  task automatic write_begin(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    xadd     = a;
    tb_wdata = d;
    tb_drv   = 1'b1;
    xcs_n    = 1'b0;
    wen      = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic write_finish(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [NCH*DW-1:0] pre0, pre1;
    pre0 = packed_out(0);
    pre1 = packed_out(1);
    wen  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dsp0 !== pre0 || dsp1 !== pre1 || upd0 !== '0 || upd1 !== '0 || com0 !== 1'b0 || com1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_early: dsp0=%h dsp1=%h upd0=%h upd1=%h com=%b%b, required unchanged/no pulses",
               name, dsp0, dsp1, upd0, upd1, com0, com1);
    end
    model_write(a, d);
    @(negedge clk);
    checks++;
    if (dsp0 !== packed_out(0)) begin
      errors++;
      $display("[TB] FAIL %s_dsp0: got %h required %h", name, dsp0, packed_out(0));
    end
    checks++;
    if (dsp1 !== packed_out(1)) begin
      errors++;
      $display("[TB] FAIL %s_dsp1: got %h required %h", name, dsp1, packed_out(1));
    end
    checks++;
    if (upd0 !== e_upd0 || upd1 !== e_upd1) begin
      errors++;
      $display("[TB] FAIL %s_upd: got %h/%h required %h/%h", name, upd0, upd1, e_upd0, e_upd1);
    end
    checks++;
    if (com0 !== e_com || com1 !== e_com) begin
      errors++;
      $display("[TB] FAIL %s_commit: got %b/%b required %b", name, com0, com1, e_com);
    end
    @(negedge clk);
    checks++;
    if (upd0 !== '0 || upd1 !== '0 || com0 !== 1'b0 || com1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_pulse_len: upd=%h/%h com=%b%b required all 0", name, upd0, upd1, com0, com1);
    end
    xcs_n  = 1'b1;
    tb_drv = 1'b0;
  endtask

  task automatic bus_write(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_begin(a, d);
    write_finish(name, a, d);
  endtask

  task automatic bus_read(input string name, input logic [AW-1:0] a);
    logic [DW-1:0] exp;
    exp = model_read(a);
    @(negedge clk);
    xadd  = a;
    xcs_n = 1'b0;
    ren   = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (k < 3 ? !(undriven(xdata0) && undriven(xdata1)) : (xdata0 !== exp || xdata1 !== exp)) begin
        errors++;
        $display("[TB] FAIL %s_active_%0d: xdata=%h/%h required %s %h", name, k, xdata0, xdata1,
                 k < 3 ? "high-Z, not" : "", exp);
      end
    end
    ren   = 1'b1;
    xcs_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (k < 3 ? (xdata0 !== exp || xdata1 !== exp) : !(undriven(xdata0) && undriven(xdata1))) begin
        errors++;
        $display("[TB] FAIL %s_trail_%0d: xdata=%h/%h required %s %h", name, k, xdata0, xdata1,
                 k < 3 ? "" : "high-Z, not", exp);
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if (dsp0 !== '0 || dsp1 !== '0 || upd0 !== '0 || upd1 !== '0 || com0 !== 1'b0 || com1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: dsp0=%h dsp1=%h upd=%h/%h com=%b%b required 0",
               dsp0, dsp1, upd0, upd1, com0, com1);
    end
    checks++;
    if (!(undriven(xdata0) && undriven(xdata1))) begin
      errors++;
      $display("[TB] FAIL reset_xdata: got %h/%h required high-Z", xdata0, xdata1);
    end
    @(negedge clk);
    global_rst = 1'b1;
    repeat (3) @(negedge clk);
    bus_read("reset_status", BASE + AW'(NCH + 1));
  endtask

  task automatic test_direct_write();
    bus_write("ch2_a5a5", 20'h0FC03, 16'hA5A5);
    checks++;
    if (dsp0[2*DW +: DW] !== 16'hA5A5) begin
      errors++;
      $display("[TB] FAIL ch2_value: got %h required a5a5", dsp0[2*DW +: DW]);
    end
    bus_read("status_after_ch2", BASE + AW'(NCH + 1));
  endtask

  task automatic test_unmapped();
    bus_write("status_clear", BASE + AW'(NCH + 1), DW'($urandom));
    bus_write("unmapped_first", 20'h0FC20, 16'h1234);
    bus_read("status_unm1", BASE + AW'(NCH + 1));
    for (int n = 0; n < 256; n++) begin
      bus_write("unmapped_sat", 20'h0FC20 + AW'($urandom_range(0, 15)), DW'($urandom));
    end
    bus_read("status_unm_sat", BASE + AW'(NCH + 1));
  endtask

  task automatic test_commit();
    bus_write("shadow_ch0", BASE, 16'h1111);
    bus_write("shadow_ch7", BASE + 20'd7, 16'h7777);
    bus_write("commit_zero", BASE + AW'(NCH), 16'h0000);
    bus_write("commit_one", BASE + AW'(NCH), 16'h0001);
    checks++;
    if (dsp1[0 +: DW] !== 16'h1111 || dsp1[7*DW +: DW] !== 16'h7777) begin
      errors++;
      $display("[TB] FAIL commit_values: ch0=%h ch7=%h required 1111/7777", dsp1[0 +: DW], dsp1[7*DW +: DW]);
    end
  endtask

  task automatic test_read();
    bus_write("ch0_beef", BASE, 16'hBEEF);
    bus_read("read_ch0", BASE);
    bus_read("read_commit", BASE + AW'(NCH));
    bus_read("read_unmapped", 20'h0FC20);
    bus_read("read_status", BASE + AW'(NCH + 1));
  endtask

  task automatic test_both_low();
    @(negedge clk);
    xadd   = BASE;
    tb_drv = 1'b0;
    xcs_n  = 1'b0;
    wen    = 1'b0;
    ren    = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (!(undriven(xdata0) && undriven(xdata1))) begin
        errors++;
        $display("[TB] FAIL both_low_%0d: xdata=%h/%h required high-Z", k, xdata0, xdata1);
      end
    end
    tb_wdata = 16'h0C0D;
    tb_drv   = 1'b1;
    ren      = 1'b1;
    repeat (3) @(negedge clk);
    write_finish("both_low_write", BASE, 16'h0C0D);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int            r;
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)       a = BASE + AW'($urandom_range(0, NCH - 1));
      else if (r == 6) a = BASE + AW'(NCH);
      else if (r == 7) a = BASE + AW'(NCH + 1);
      else if (r == 8) a = BASE - 20'd1;
      else             a = BASE + AW'(NCH + 2) + AW'($urandom_range(0, 20));
      bus_write("random", a, DW'($urandom));
      if (n % 6 == 5) begin
        if ($urandom_range(0, 1) == 1) bus_read("random_read", BASE + AW'($urandom_range(0, NCH - 1)));
        else                            bus_read("random_status", BASE + AW'(NCH + 1));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    write_begin(BASE + 20'd3, 16'h5A5A);
    #2 global_rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dsp0 !== '0 || dsp1 !== '0 || upd0 !== '0 || upd1 !== '0 || com0 !== 1'b0 || com1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: dsp0=%h dsp1=%h upd=%h/%h com=%b%b required 0",
               dsp0, dsp1, upd0, upd1, com0, com1);
    end
    @(negedge clk);
    #2 global_rst = 1'b1;
    repeat (4) @(negedge clk);
    wen = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (dsp0 !== '0 || dsp1 !== '0 || upd0 !== '0 || upd1 !== '0 || com0 !== 1'b0 || com1 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_no_event_%0d: dsp0=%h dsp1=%h upd=%h/%h required 0",
                 k, dsp0, dsp1, upd0, upd1);
      end
    end
    xcs_n  = 1'b1;
    tb_drv = 1'b0;
    bus_read("midreset_status", BASE + AW'(NCH + 1));
    bus_write("post_reset_write", BASE + 20'd5, 16'h0F0F);
  endtask

  initial begin
    test_reset();
    test_direct_write();
    test_unmapped();
    test_commit();
    test_read();
    test_both_low();
    test_random();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
